regfile_2r1w: RTL and testbench

Parametrised register file, successor to the fixed 8×8 single-port register file: WIDTH-bit entries, DEPTH entries, one write port and two independently enabled registered read ports. After reset, an init sequencer clears the array one entry per cycle, so the storage can map onto RAM rather than flops. The block serves as the operand store for the datapath and drives both ALU operand buses in one cycle.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_init_seq.sv | 56 +++++
 rtl/regfile_2r1w.sv | 92 +++++++++
 tb/tb_regfile_2r1w.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes
// for the regfile_2r1w operand store.
package regfile_pkg;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

  localparam int RF_WIDTH_DEF = 8;
  localparam int RF_DEPTH_DEF = 8;

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: post-reset clear sequencer, walks ptr
// over every entry once, then holds READY until clr.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_e     state_q;
  rf_state_e     state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RF_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      RF_INIT: begin
        clr_we = ~clr;
        // ptr parks on the last entry; no wrap
        if (ptr_q == LAST) begin
          state_d = RF_READY;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RF_READY: begin
        state_d = RF_READY;
      end
    endcase
  end

  assign ready    = (state_q == RF_READY);
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 1W/2R register file, registered reads.
// Define REGFILE_BYPASS_EN for write-first collisions.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH_DEF,
  parameter int DEPTH = RF_DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  output logic             ready,
  input  logic             wen,
  input  logic [AW-1:0]    wsel,
  input  logic [WIDTH-1:0] d,
  input  logic             ren_a,
  input  logic [AW-1:0]    rsel_a,
  input  logic             ren_b,
  input  logic [AW-1:0]    rsel_b,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             w_ok;
  logic             a_ok;
  logic             b_ok;
  logic             a_hit;
  logic             b_hit;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;

  regfile_init_seq #(
    .DEPTH(DEPTH)
  ) u_init (
    .clk     (clk),
    .clr     (clr),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign w_ok = ready & wen & ~clr
              & ({1'b0, wsel} < DEPTH_W);
  assign a_ok = ({1'b0, rsel_a} < DEPTH_W);
  assign b_ok = ({1'b0, rsel_b} < DEPTH_W);

`ifdef REGFILE_BYPASS_EN
  assign a_hit = w_ok & (wsel == rsel_a);
  assign b_hit = w_ok & (wsel == rsel_b);
`else
  assign a_hit = 1'b0;
  assign b_hit = 1'b0;
`endif

  // clear and user writes never overlap: ready is low in INIT
  always_comb begin
    we    = clr_we | w_ok;
    waddr = clr_we ? clr_addr : wsel;
    wdata = clr_we ? '0 : d;
  end

  always_comb begin
    a_data = '0;
    b_data = '0;
    if (a_ok) a_data = a_hit ? d : mem[rsel_a];
    if (b_ok) b_data = b_hit ? d : mem[rsel_b];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      qa <= '0;
      qb <= '0;
    end else begin
      if (ren_a) qa <= ready ? a_data : '0;
      if (ren_b) qb <= ready ? b_data : '0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: 8x8 and 6x16 instances on shared stimulus,
// checked against an init-counter reference model.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic        wen;
  logic        ren_a;
  logic        ren_b;
  logic [2:0]  wsel;
  logic [2:0]  rsel_a;
  logic [2:0]  rsel_b;
  logic [15:0] d;

  logic        rdy8;
  logic        rdy6;
  logic [7:0]  qa8;
  logic [7:0]  qb8;
  logic [15:0] qa6;
  logic [15:0] qb6;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(8), .DEPTH(8)) u_rf8 (
    .clk   (clk),
    .clr   (clr),
    .ready (rdy8),
    .wen   (wen),
    .wsel  (wsel),
    .d     (d[7:0]),
    .ren_a (ren_a),
    .rsel_a(rsel_a),
    .ren_b (ren_b),
    .rsel_b(rsel_b),
    .qa    (qa8),
    .qb    (qb8)
  );

  regfile_2r1w #(.WIDTH(16), .DEPTH(6)) u_rf6 (
    .clk   (clk),
    .clr   (clr),
    .ready (rdy6),
    .wen   (wen),
    .wsel  (wsel),
    .d     (d),
    .ren_a (ren_a),
    .rsel_a(rsel_a),
    .ren_b (ren_b),
    .rsel_b(rsel_b),
    .qa    (qa6),
    .qb    (qb6)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // model: index 0 is the 8x8 instance, 1 the 6x16
  int          dep  [2] = '{8, 6};
  logic [15:0] mask [2] = '{16'h00ff, 16'hffff};
  int          cnt  [2];
  logic [15:0] mm   [2][8];
  logic [15:0] ea   [2];
  logic [15:0] eb   [2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  task automatic model_tick();
    logic [15:0] dk;
    bit          hit_w;
    for (int k = 0; k < 2; k++) begin
      dk    = d & mask[k];
      hit_w = wen && (int'(wsel) < dep[k]);
      if (clr) begin
        cnt[k] = 0;
        ea[k]  = '0;
        eb[k]  = '0;
        for (int i = 0; i < 8; i++) mm[k][i] = '0;
      end else if (cnt[k] < dep[k]) begin
        cnt[k]++;
        if (ren_a) ea[k] = '0;
        if (ren_b) eb[k] = '0;
      end else begin
        if (ren_a) begin
          if (int'(rsel_a) >= dep[k]) ea[k] = '0;
          else if (BYP && hit_w && wsel == rsel_a) ea[k] = dk;
          else ea[k] = mm[k][rsel_a];
        end
        if (ren_b) begin
          if (int'(rsel_b) >= dep[k]) eb[k] = '0;
          else if (BYP && hit_w && wsel == rsel_b) eb[k] = dk;
          else eb[k] = mm[k][rsel_b];
        end
        if (hit_w) mm[k][wsel] = dk;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk("rdy8", 32'(rdy8), 32'(cnt[0] >= dep[0]));
    chk("qa8",  32'(qa8),  32'(ea[0]));
    chk("qb8",  32'(qb8),  32'(eb[0]));
    chk("rdy6", 32'(rdy6), 32'(cnt[1] >= dep[1]));
    chk("qa6",  32'(qa6),  32'(ea[1]));
    chk("qb6",  32'(qb6),  32'(eb[1]));
  endtask

  initial begin
    clr = 1'b1; wen = 1'b0; d = '0; wsel = '0;
    ren_a = 1'b0; ren_b = 1'b0;
    rsel_a = '0; rsel_b = '0;
    step(); step();

    // write during INIT must be dropped
    clr = 1'b0;
    wen = 1'b1; wsel = 3'd3; d = 16'h00aa;
    ren_a = 1'b1; rsel_a = 3'd3;
    ren_b = 1'b1; rsel_b = 3'd0;
    repeat (8) step();
    wen = 1'b0;
    step();

    // basic write then dual read, then hold
    wen = 1'b1; wsel = 3'd2; d = 16'h5a5a; step();
    wsel = 3'd7; d = 16'hc3c3; step();
    wen = 1'b0;
    ren_a = 1'b1; rsel_a = 3'd2;
    ren_b = 1'b1; rsel_b = 3'd7;
    step();
    ren_a = 1'b0; ren_b = 1'b0;
    rsel_a = 3'd7;
    step(); step();

    // read/write collision on port A
    wen = 1'b1; wsel = 3'd4; d = 16'h1111; step();
    d = 16'h2222; ren_a = 1'b1; rsel_a = 3'd4; step();
    wen = 1'b0; step();

    // clr during INIT restarts the count
    clr = 1'b1; step();
    clr = 1'b0; repeat (3) step();
    clr = 1'b1; step();
    clr = 1'b0; repeat (9) step();

    // random traffic with rare clr
    repeat (2000) begin
      clr    = ($urandom_range(0, 149) == 0);
      wen    = $urandom_range(0, 1) == 1;
      wsel   = 3'($urandom_range(0, 7));
      d      = 16'($urandom);
      ren_a  = $urandom_range(0, 3) != 0;
      ren_b  = $urandom_range(0, 3) != 0;
      rsel_a = 3'($urandom_range(0, 7));
      rsel_b = 3'($urandom_range(0, 7));
      step();
    end

    // fill, clr in READY, re-init, read all back
    clr = 1'b0; ren_a = 1'b0; ren_b = 1'b0;
    repeat (10) step();
    wen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wsel = 3'(i); d = 16'($urandom) | 16'h0101;
      step();
    end
    wen = 1'b0;
    clr = 1'b1; step();
    clr = 1'b0; repeat (8) step();
    ren_a = 1'b1; ren_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rsel_a = 3'(i); rsel_b = 3'(7 - i);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
